gpio_cfg_sequencer: RTL and testbench

GPIO_CFG_SEQUENCER -- requirements
Module: gpio_cfg_sequencer

---
 rtl/gpio_cfg_pkg.sv | 18 +
 rtl/gpio_cfg_clkdiv.sv | 37 +++
 rtl/gpio_cfg_sequencer.sv | 178 +++++++++++++++++
 tb/tb_gpio_cfg_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg
//   Shared definitions for the GPIO pad configuration sequencer:
//   - sequencer state encoding
//   - default per-pad configuration width and reset value
package gpio_cfg_pkg;

    localparam int          GPIO_PAD_CTRL_BITS = 12;
    localparam logic [11:0] GPIO_PAD_DEFAULT   = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LOAD     = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/gpio_cfg_clkdiv.sv
// gpio_cfg_clkdiv
//   Phase counter for the serial chain clock. While enabled it counts
//   CLK_DIV mclk cycles per phase and pulses o_phase_tick on the last
//   cycle of each phase. Disabling it parks the count at zero so every
//   sequence starts on a full phase.
// Ports:
//   i_mclk        system clock
//   i_reset       synchronous active-high reset
//   i_en          count enable (sequencer is in a timed state)
//   o_phase_tick  high on the final mclk cycle of each CLK_DIV phase
module gpio_cfg_clkdiv #(
    parameter int CLK_DIV = 2
) (
    input  logic i_mclk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_phase_tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_mclk) begin
        if (i_reset || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_phase_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// gpio_cfg_sequencer
//   Holds a shadow copy of every pad's configuration word and, on start,
//   shifts the whole shadow into a serial pad-control chain (last pad
//   first, MSB first), then pulses the chain load strobe.
// Ports:
//   mclk, reset       system clock, synchronous active-high reset
//   cfg_wr_en/addr/data  shadow write port (ignored while busy)
//   cfg_wr_err        one-cycle pulse the cycle after a rejected write
//   start             push the shadow into the chain (accepted in IDLE only)
//   busy, done        sequence in progress / one-cycle end pulse
//   serial_clock, serial_load, serial_data_out  chain head drive
module gpio_cfg_sequencer
    import gpio_cfg_pkg::*;
#(
    parameter int                       NUM_PADS      = 15,
    parameter int                       PAD_CTRL_BITS = GPIO_PAD_CTRL_BITS,
    parameter logic [PAD_CTRL_BITS-1:0] PAD_DEFAULT   = GPIO_PAD_DEFAULT,
    parameter int                       CLK_DIV       = 2,
    localparam int                      AW            = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                     mclk,
    input  logic                     reset,
    input  logic                     cfg_wr_en,
    input  logic [AW-1:0]            cfg_wr_addr,
    input  logic [PAD_CTRL_BITS-1:0] cfg_wr_data,
    output logic                     cfg_wr_err,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     serial_clock,
    output logic                     serial_load,
    output logic                     serial_data_out
);

    localparam int             NB       = NUM_PADS * PAD_CTRL_BITS;
    localparam int             BCW      = $clog2(NB + 1);
    localparam int             FLAT_W   = 1 << BCW;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(NB - 1);
    localparam logic [31:0]    NP32     = NUM_PADS;

    logic [PAD_CTRL_BITS-1:0] r_shadow [NUM_PADS];
    seq_state_t               r_state;
    logic [BCW-1:0]           r_bit_cnt;
    logic                     r_load_half;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_sclk;
    logic                     r_sload;
    logic                     r_sdo;
    logic                     r_wr_err;

    logic [FLAT_W-1:0]        w_flat;
    logic [BCW-1:0]           w_next_cnt;
    logic [BCW-1:0]           w_next_idx;
    logic                     w_addr_ok;
    logic                     w_wr_ok;
    logic                     w_div_en;
    logic                     w_tick;

    // Shadow flattened as {pad N-1, ..., pad 0}: shift order is simply
    // descending bit index. Padded to a power of two so the bit counter
    // indexes it at its natural width.
    genvar g;
    generate
        for (g = 0; g < NUM_PADS; g++) begin : g_flat
            assign w_flat[g*PAD_CTRL_BITS +: PAD_CTRL_BITS] = r_shadow[g];
        end
        if (FLAT_W > NB) begin : g_pad
            assign w_flat[FLAT_W-1:NB] = '0;
        end
    endgenerate

    assign w_next_cnt = r_bit_cnt + 1'b1;
    assign w_next_idx = LAST_BIT - w_next_cnt;
    assign w_addr_ok  = ({{(32-AW){1'b0}}, cfg_wr_addr} < NP32);
    assign w_wr_ok    = cfg_wr_en && !r_busy && w_addr_ok;
    assign w_div_en   = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) ||
                        (r_state == ST_LOAD);

    gpio_cfg_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .i_mclk       (mclk),
        .i_reset      (reset),
        .i_en         (w_div_en),
        .o_phase_tick (w_tick)
    );

    always_ff @(posedge mclk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PADS; p++) r_shadow[p] <= PAD_DEFAULT;
        end else if (w_wr_ok) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (cfg_wr_addr == AW'(p)) r_shadow[p] <= cfg_wr_data;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) r_wr_err <= 1'b0;
        else       r_wr_err <= cfg_wr_en && !w_wr_ok;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_load_half <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sclk      <= 1'b0;
            r_sload     <= 1'b0;
            r_sdo       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_SHIFT_LO;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_sclk    <= 1'b0;
                        r_sdo     <= w_flat[NB-1];
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT_HI;
                        r_sclk  <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_tick) begin
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= w_next_cnt;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state     <= ST_LOAD;
                            r_sload     <= 1'b1;
                            r_load_half <= 1'b0;
                        end else begin
                            // Next bit changes together with the falling edge.
                            r_state <= ST_SHIFT_LO;
                            r_sdo   <= w_flat[w_next_idx];
                        end
                    end
                end
                ST_LOAD: begin
                    // Two phase ticks give the 2*CLK_DIV load pulse.
                    if (w_tick) begin
                        if (r_load_half) begin
                            r_state <= ST_DONE;
                            r_sload <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_load_half <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_bit_cnt   <= '0;
                    r_load_half <= 1'b0;
                    r_sdo       <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_wr_err      = r_wr_err;
    assign busy            = r_busy;
    assign done            = r_done;
    assign serial_clock    = r_sclk;
    assign serial_load     = r_sload;
    assign serial_data_out = r_sdo;

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
module tb_gpio_cfg_sequencer;

    logic        mclk = 1'b0;
    logic        reset;

    logic        a_wr_en, a_start;
    logic [3:0]  a_wr_addr;
    logic [11:0] a_wr_data;
    logic        a_err, a_busy, a_done, a_sclk, a_sload, a_sdo;

    logic        b_wr_en, b_start;
    logic [0:0]  b_wr_addr;
    logic [11:0] b_wr_data;
    logic        b_err, b_busy, b_done, b_sclk, b_sload, b_sdo;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [11:0] m_shadow [15];
    logic [11:0] m_b;

    always #5 mclk = ~mclk;

    gpio_cfg_sequencer u_a (
        .mclk(mclk), .reset(reset),
        .cfg_wr_en(a_wr_en), .cfg_wr_addr(a_wr_addr), .cfg_wr_data(a_wr_data),
        .cfg_wr_err(a_err), .start(a_start), .busy(a_busy), .done(a_done),
        .serial_clock(a_sclk), .serial_load(a_sload), .serial_data_out(a_sdo)
    );

    gpio_cfg_sequencer #(.NUM_PADS(1), .CLK_DIV(1)) u_b (
        .mclk(mclk), .reset(reset),
        .cfg_wr_en(b_wr_en), .cfg_wr_addr(b_wr_addr), .cfg_wr_data(b_wr_data),
        .cfg_wr_err(b_err), .start(b_start), .busy(b_busy), .done(b_done),
        .serial_clock(b_sclk), .serial_load(b_sload), .serial_data_out(b_sdo)
    );

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 15; p++) m_shadow[p] = 12'hC00;
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [11:0] data,
                        output logic err1, output logic err2);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        tick();
        a_wr_en = 1'b0;
        err1 = a_err;
        tick();
        err2 = a_err;
    endtask

    // Runs one sequence on instance A starting in the current cycle (cycle 0)
    // and measures it against the shadow model and a shift-register chain model.
    task automatic run_a(input int hold, input bit poke_done, input int busy_wr_cyc,
                         output int edges, output int bad_bits, output int load_cyc,
                         output int done_cyc, output int done_cnt, output int busy_bad,
                         output int chain_bad, output logic busy_wr_err);
        bit [179:0]  chain, latched, tmp;
        bit          prev_sclk, prev_load, exp_busy;
        logic [3:0]  pidx, bidx;
        edges = 0; bad_bits = 0; load_cyc = 0; done_cyc = -1; done_cnt = 0;
        busy_bad = 0; chain_bad = 0; busy_wr_err = 1'bx;
        chain = '0; latched = '0; prev_sclk = 1'b0; prev_load = 1'b0;
        a_start = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            tick();
            if (a_sclk && !prev_sclk) begin
                if (edges < 180) begin
                    pidx = 4'(14 - edges / 12);
                    bidx = 4'(11 - edges % 12);
                    if (a_sdo !== m_shadow[pidx][bidx]) bad_bits++;
                end else begin
                    bad_bits++;
                end
                chain = {chain[178:0], a_sdo};
                edges++;
            end
            if (a_sload) begin
                load_cyc++;
                if (!prev_load) latched = chain;
            end
            if (a_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            exp_busy = (done_cyc < 0) || (cyc == done_cyc);
            if (a_busy !== exp_busy) busy_bad++;
            if (busy_wr_cyc != 0 && cyc == busy_wr_cyc + 1) busy_wr_err = a_err;
            prev_sclk = a_sclk;
            prev_load = a_sload;
            a_start = (cyc < hold) || (poke_done && a_done);
            a_wr_en = 1'b0;
            if (cyc == busy_wr_cyc) begin
                a_wr_en   = 1'b1;
                a_wr_addr = 4'($urandom_range(0, 14));
                a_wr_data = 12'($urandom);
            end
            if (done_cyc > 0 && cyc >= done_cyc + 12) break;
        end
        a_start = 1'b0;
        a_wr_en = 1'b0;
        for (int p = 0; p < 15; p++) begin
            tmp = latched >> (p * 12);
            if (tmp[11:0] !== m_shadow[p]) chain_bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        model_reset();
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", a_done); end
        n_checks++; if (a_sclk !== 1'b0) begin n_errors++; $display("FAIL reset_sclk: got %b want 0", a_sclk); end
        n_checks++; if (a_sload !== 1'b0) begin n_errors++; $display("FAIL reset_sload: got %b want 0", a_sload); end
        n_checks++; if (a_sdo !== 1'b0) begin n_errors++; $display("FAIL reset_sdo: got %b want 0", a_sdo); end
        n_checks++; if (a_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", a_err); end
        n_checks++; if ({b_busy, b_done, b_sclk, b_sload, b_sdo, b_err} !== 6'b0) begin
            n_errors++; $display("FAIL reset_b_outputs: got %b want 000000", {b_busy, b_done, b_sclk, b_sload, b_sdo, b_err});
        end
    endtask

    task automatic check_seq(input string tag, input int edges, input int bad_bits,
                             input int load_cyc, input int done_cyc, input int done_cnt,
                             input int busy_bad, input int chain_bad);
        n_checks++; if (edges !== 180) begin n_errors++; $display("FAIL %s_edges: got %0d want 180", tag, edges); end
        n_checks++; if (bad_bits !== 0) begin n_errors++; $display("FAIL %s_bits: got %0d wrong bits want 0", tag, bad_bits); end
        n_checks++; if (load_cyc !== 4) begin n_errors++; $display("FAIL %s_load: got %0d cycles want 4", tag, load_cyc); end
        n_checks++; if (done_cyc !== 725) begin n_errors++; $display("FAIL %s_done_cycle: got %0d want 725", tag, done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt); end
        n_checks++; if (busy_bad !== 0) begin n_errors++; $display("FAIL %s_busy: got %0d bad cycles want 0", tag, busy_bad); end
        n_checks++; if (chain_bad !== 0) begin n_errors++; $display("FAIL %s_chain: got %0d bad pads want 0", tag, chain_bad); end
    endtask

    task automatic test_default_sequence();
        int e, bb, lc, dc, dn, bu, cb;
        logic we;
        run_a(1, 1'b0, 0, e, bb, lc, dc, dn, bu, cb, we);
        check_seq("default", e, bb, lc, dc, dn, bu, cb);
    endtask

    task automatic test_pad_writes();
        int e, bb, lc, dc, dn, bu, cb;
        logic we, e1, e2;
        logic [3:0]  addr;
        logic [11:0] data;
        wr_a(4'd0, 12'hABC, e1, e2);
        m_shadow[0] = 12'hABC;
        n_checks++; if (e1 !== 1'b0) begin n_errors++; $display("FAIL wr_pad0_err: got %b want 0", e1); end
        wr_a(4'd14, 12'h123, e1, e2);
        m_shadow[14] = 12'h123;
        n_checks++; if (e1 !== 1'b0) begin n_errors++; $display("FAIL wr_pad14_err: got %b want 0", e1); end
        for (int i = 0; i < 5; i++) begin
            addr = 4'($urandom_range(1, 13));
            data = 12'($urandom);
            wr_a(addr, data, e1, e2);
            m_shadow[addr] = data;
        end
        run_a(1, 1'b0, 0, e, bb, lc, dc, dn, bu, cb, we);
        check_seq("writes", e, bb, lc, dc, dn, bu, cb);
    endtask

    task automatic test_bad_writes();
        int e, bb, lc, dc, dn, bu, cb;
        logic we, e1, e2;
        wr_a(4'd15, 12'h5A5, e1, e2);
        n_checks++; if (e1 !== 1'b1) begin n_errors++; $display("FAIL badaddr_err: got %b want 1", e1); end
        n_checks++; if (e2 !== 1'b0) begin n_errors++; $display("FAIL badaddr_err_len: got %b want 0", e2); end
        run_a(1, 1'b0, 100, e, bb, lc, dc, dn, bu, cb, we);
        n_checks++; if (we !== 1'b1) begin n_errors++; $display("FAIL busy_wr_err: got %b want 1", we); end
        check_seq("after_bad", e, bb, lc, dc, dn, bu, cb);
        // A second pass shows the write made during the first pass was dropped.
        run_a(1, 1'b0, 0, e, bb, lc, dc, dn, bu, cb, we);
        check_seq("readback", e, bb, lc, dc, dn, bu, cb);
    endtask

    task automatic test_reset_mid();
        int e, bb, lc, dc, dn, bu, cb, edges;
        logic we, prev;
        edges = 0; prev = 1'b0;
        a_start = 1'b1;
        for (int cyc = 1; cyc <= 1000 && edges < 50; cyc++) begin
            tick();
            a_start = 1'b0;
            if (a_sclk && !prev) edges++;
            prev = a_sclk;
        end
        n_checks++; if (edges !== 50) begin n_errors++; $display("FAIL mid_reach50: got %0d want 50", edges); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({a_busy, a_done, a_sclk, a_sload, a_sdo, a_err} !== 6'b0) begin
            n_errors++; $display("FAIL mid_reset_outputs: got %b want 000000", {a_busy, a_done, a_sclk, a_sload, a_sdo, a_err});
        end
        model_reset();
        tick();
        run_a(1, 1'b0, 0, e, bb, lc, dc, dn, bu, cb, we);
        check_seq("post_reset", e, bb, lc, dc, dn, bu, cb);
    endtask

    task automatic test_back_to_back();
        int e, bb, lc, dc, dn, bu, cb;
        logic we;
        m_shadow[7] = 12'h3C5;
        wr_a(4'd7, 12'h3C5, we, we);
        run_a(3, 1'b1, 0, e, bb, lc, dc, dn, bu, cb, we);
        check_seq("b2b", e, bb, lc, dc, dn, bu, cb);
        n_checks++; if (a_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_after: got busy=%b want 0", a_busy); end
    endtask

    task automatic test_small();
        int edges, bad_bits, toggle_bad, load_cyc, done_cyc, done_cnt;
        logic prev;
        m_b = 12'($urandom);
        b_wr_en = 1'b1; b_wr_addr = 1'b0; b_wr_data = m_b;
        tick();
        b_wr_en = 1'b1; b_wr_addr = 1'b1; b_wr_data = ~m_b;
        tick();
        b_wr_en = 1'b0;
        n_checks++; if (b_err !== 1'b1) begin n_errors++; $display("FAIL small_badaddr_err: got %b want 1", b_err); end
        tick();
        edges = 0; bad_bits = 0; toggle_bad = 0; load_cyc = 0; done_cyc = -1; done_cnt = 0;
        prev = 1'b0;
        b_start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            tick();
            b_start = 1'b0;
            if (cyc <= 24 && b_sclk !== ((cyc % 2) == 0)) toggle_bad++;
            if (b_sclk && !prev) begin
                if (edges < 12) begin
                    if (b_sdo !== m_b[4'(11 - edges)]) bad_bits++;
                end else begin
                    bad_bits++;
                end
                edges++;
            end
            prev = b_sclk;
            if (b_sload) load_cyc++;
            if (b_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 4) break;
        end
        n_checks++; if (edges !== 12) begin n_errors++; $display("FAIL small_edges: got %0d want 12", edges); end
        n_checks++; if (bad_bits !== 0) begin n_errors++; $display("FAIL small_bits: got %0d wrong want 0", bad_bits); end
        n_checks++; if (toggle_bad !== 0) begin n_errors++; $display("FAIL small_toggle: got %0d bad cycles want 0", toggle_bad); end
        n_checks++; if (load_cyc !== 2) begin n_errors++; $display("FAIL small_load: got %0d want 2", load_cyc); end
        n_checks++; if (done_cyc !== 27) begin n_errors++; $display("FAIL small_done_cycle: got %0d want 27", done_cyc); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL small_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (b_busy !== 1'b0) begin n_errors++; $display("FAIL small_busy_after: got %b want 0", b_busy); end
    endtask

    initial begin
        reset = 1'b1;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_start = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0;
        test_reset();
        test_default_sequence();
        test_pad_writes();
        test_bad_writes();
        test_reset_mid();
        test_back_to_back();
        test_small();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
